// File: rtl/imm_pkg.sv
// Shared encodings for the pipelined immediate generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imm_pkg;

    // Immediate format selects carried on in_imm_src.
    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;
    localparam logic [2:0] IMM_ZIMM  = 3'b110;
    localparam logic [2:0] IMM_ILL   = 3'b111;

    // Occupancy of the output register + skid register pair.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } st_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32/RV64 immediate decoder, result extended to XLEN.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle from the current inputs.
// Ports: instr (raw word), src (format select) -> imm (extended), illegal (select 111).
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Every format is first assembled as a 32-bit value that is already
    // correctly extended to 32 bits; zero-extended formats keep bit 31 clear,
    // so one signed widening covers both extension kinds for XLEN=64.
    logic [31:0] v32;

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        v32     = '0;
        illegal = 1'b0;
        case (src)
            IMM_I:     v32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     v32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     v32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_U:     v32 = {instr[31:12], 12'b0};
            IMM_J:     v32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            IMM_SHAMT: v32 = (XLEN == 64) ? {26'b0, instr[25:20]}
                                          : {27'b0, instr[24:20]};
            IMM_ZIMM:  v32 = {27'b0, instr[19:15]};
            default: begin
                v32     = '0;
                illegal = 1'b1;
            end
        endcase
        imm = XLEN'($signed(v32));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode, register, present via valid/ready with 2-entry skid.
// Latency: 1 cycle from input acceptance to out_valid at the earliest.
// Backpressure: in_ready depends only on held state, flush and rst; never on out_ready.
// Ports: clk, rst (async high), flush; in_valid/in_ready/in_instr/in_imm_src/in_tag;
//        out_valid/out_ready/out_imm/out_tag/out_illegal; illegal_cnt (saturating).
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,   // 32 or 64 only
    parameter int TAG_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    st_t state, state_nxt;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;

    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_illegal;

    logic accept, pop;
    logic load_out, load_skid, move_skid;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr   (in_instr),
        .src     (in_imm_src),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign in_ready  = (state != ST_TWO) && !flush && !rst;
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    // Next state and datapath steering. The output register takes a new beat
    // when it is empty or being drained in the same cycle; otherwise the new
    // beat parks in the skid register. Flush wins over everything; accept is
    // already blocked by in_ready during flush.
    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        load_out  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        load_out  = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_TWO;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_nxt = ST_ONE;
                        move_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_imm      <= '0;
            out_tag      <= '0;
            out_illegal  <= 1'b0;
            skid_imm     <= '0;
            skid_tag     <= '0;
            skid_illegal <= 1'b0;
        end else begin
            if (load_out) begin
                out_imm     <= dec_imm;
                out_tag     <= in_tag;
                out_illegal <= dec_illegal;
            end else if (move_skid) begin
                out_imm     <= skid_imm;
                out_tag     <= skid_tag;
                out_illegal <= skid_illegal;
            end
            if (load_skid) begin
                skid_imm     <= dec_imm;
                skid_tag     <= in_tag;
                skid_illegal <= dec_illegal;
            end
        end
    end

    // Counts accepted illegal beats; flush does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (accept && dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32/CNT_W=2 and XLEN=64/CNT_W=8 instances share one stimulus stream.
// Latency: n/a.
// Backpressure: driven from directed sequences and random out_ready.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [2:0]  in_imm_src = '0;
    logic [31:0] in_tag = '0;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm, a_out_tag;
    logic [1:0]  a_cnt;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm;
    logic [31:0] b_out_tag;
    logic [7:0]  b_cnt;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
        .out_tag(a_out_tag), .out_illegal(a_out_illegal), .illegal_cnt(a_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
        .out_tag(b_out_tag), .out_illegal(b_out_illegal), .illegal_cnt(b_cnt)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [31:0] tag;
        logic        ill;
    } beat_t;

    beat_t q[$];
    int    cnt32 = 0;
    int    cnt64 = 0;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] instr;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        ill;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Sign-extend a field of the given width held in the low bits of v.
    function automatic longint sx(input longint v, input int bits);
        if (((v >> (bits - 1)) & 1) != 0) return v - (longint'(1) << bits);
        return v;
    endfunction

    // Reference immediate, assembled arithmetically from field positions.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                            input bit is64);
        longint x;
        longint r;
        x = longint'({32'b0, ins});
        case (src)
            3'd0: r = sx((x >> 20) & 4095, 12);
            3'd1: r = sx((((x >> 25) & 127) << 5) + ((x >> 7) & 31), 12);
            3'd2: r = sx((((x >> 31) & 1) << 12) + (((x >> 7) & 1) << 11)
                         + (((x >> 25) & 63) << 5) + (((x >> 8) & 15) << 1), 13);
            3'd3: r = sx(x & 64'hFFFF_F000, 32);
            3'd4: r = sx((((x >> 31) & 1) << 20) + (((x >> 12) & 255) << 12)
                         + (((x >> 20) & 1) << 11) + (((x >> 21) & 1023) << 1), 21);
            3'd5: r = (x >> 20) & (is64 ? 63 : 31);
            3'd6: r = (x >> 15) & 31;
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic check_out();
        chk("out_valid32", a_out_valid, q.size() > 0);
        chk("out_valid64", b_out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_imm32", a_out_imm, q[0].imm32);
            chk("out_imm64", b_out_imm, q[0].imm64);
            chk("out_tag32", a_out_tag, q[0].tag);
            chk("out_tag64", b_out_tag, q[0].tag);
            chk("out_ill32", a_out_illegal, q[0].ill);
            chk("out_ill64", b_out_illegal, q[0].ill);
        end
        chk("cnt32", a_cnt, cnt32);
        chk("cnt64", b_cnt, cnt64);
    endtask

    // One clock: drive inputs at the falling edge, check in_ready, advance the
    // model, then check the outputs at the next falling edge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [2:0] src,
                        input logic [31:0] tag, input logic ordy, input logic fl);
        bit          acc, pop;
        beat_t       b;
        logic [63:0] t;
        in_valid = iv; in_instr = ins; in_imm_src = src; in_tag = tag;
        out_ready = ordy; flush = fl;
        #1;
        chk("in_ready32", a_in_ready, (q.size() < 2) && !fl);
        chk("in_ready64", b_in_ready, (q.size() < 2) && !fl);
        acc = iv && (q.size() < 2) && !fl;
        pop = (q.size() > 0) && ordy;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) b = q.pop_front();
            if (acc) begin
                b.imm64 = ref_imm(ins, src, 1'b1);
                t       = ref_imm(ins, src, 1'b0);
                b.imm32 = t[31:0];
                b.tag   = tag;
                b.ill   = (src == 3'd7);
                q.push_back(b);
                if (src == 3'd7) begin
                    if (cnt32 < 3)   cnt32++;
                    if (cnt64 < 255) cnt64++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    vec_t        tbl[8];
    logic [31:0] hold_imm, hold_tag;
    logic [1:0]  saved_cnt;

    initial begin
        tbl[0] = '{3'd0, 32'hFFF0_0093, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[1] = '{3'd1, 32'hFE11_2E23, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        tbl[2] = '{3'd2, 32'hFE00_0CE3, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
        tbl[3] = '{3'd4, 32'h0010_00EF, 32'h0000_0800, 64'h0000_0000_0000_0800, 1'b0};
        tbl[4] = '{3'd3, 32'h8000_0037, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0};
        tbl[5] = '{3'd5, 32'h03F0_D093, 32'h0000_001F, 64'h0000_0000_0000_003F, 1'b0};
        tbl[6] = '{3'd6, 32'h000F_D073, 32'h0000_001F, 64'h0000_0000_0000_001F, 1'b0};
        tbl[7] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b1};

        // Reset state.
        #1;
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_imm64", b_out_imm, 0);
        chk("rst_cnt", a_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", a_in_ready, 1);

        // Formats on consecutive cycles, each seen one cycle after acceptance.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].instr, tbl[i].src, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
            chk("tbl_imm32", a_out_imm, tbl[i].exp32);
            chk("tbl_imm64", b_out_imm, tbl[i].exp64);
            chk("tbl_tag", a_out_tag, 32'h1000 + 32'(i * 4));
            chk("tbl_ill", b_out_illegal, tbl[i].ill);
        end
        step(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        chk("ill_cnt_one", a_cnt, 1);

        // Five more illegal beats: narrow counter saturates at 3.
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'hFFFF_FFFF, 3'd7, 32'h2000 + 32'(i), 1'b1, 1'b0);
        step(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        chk("ill_cnt_sat32", a_cnt, 3);
        chk("ill_cnt_64", b_cnt, 6);

        // Backpressure: two accepted, third refused; hold stable; drain in order.
        step(1'b1, 32'h0010_0093, 3'd0, 32'hA0, 1'b0, 1'b0);
        step(1'b1, 32'h0020_0093, 3'd0, 32'hA1, 1'b0, 1'b0);
        step(1'b1, 32'h0030_0093, 3'd0, 32'hA2, 1'b0, 1'b0);
        hold_imm = a_out_imm;
        hold_tag = a_out_tag;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h0030_0093, 3'd0, 32'hA2, 1'b0, 1'b0);
            chk("hold_imm", a_out_imm, hold_imm);
            chk("hold_tag", a_out_tag, hold_tag);
        end
        step(1'b1, 32'h0030_0093, 3'd0, 32'hA2, 1'b1, 1'b0);
        chk("drain_tag_a1", a_out_tag, 32'hA1);
        step(1'b1, 32'h0030_0093, 3'd0, 32'hA2, 1'b1, 1'b0);
        chk("drain_tag_a2", a_out_tag, 32'hA2);
        step(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);

        // Flush from TWO with an illegal beat offered.
        step(1'b1, 32'h0040_0093, 3'd0, 32'hB0, 1'b0, 1'b0);
        step(1'b1, 32'h0050_0093, 3'd0, 32'hB1, 1'b0, 1'b0);
        saved_cnt = a_cnt;
        step(1'b1, 32'hFFFF_FFFF, 3'd7, 32'hB2, 1'b0, 1'b1);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", a_out_valid, 0);
        chk("flush_in_ready", a_in_ready, 1);
        chk("flush_cnt", a_cnt, saved_cnt);
        @(negedge clk);

        // Asynchronous reset mid-stream while in TWO.
        step(1'b1, 32'h0060_0093, 3'd0, 32'hC0, 1'b0, 1'b0);
        step(1'b1, 32'h0070_0093, 3'd0, 32'hC1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", a_out_valid, 0);
        chk("arst_out_imm", a_out_imm, 0);
        chk("arst_out_tag", b_out_tag, 0);
        chk("arst_out_ill", a_out_illegal, 0);
        chk("arst_cnt32", a_cnt, 0);
        chk("arst_cnt64", b_cnt, 0);
        chk("arst_in_ready", a_in_ready, 0);
        q.delete();
        cnt32 = 0;
        cnt64 = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_rel_in_ready", b_in_ready, 1);
        step(1'b1, 32'hFE11_2E23, 3'd1, 32'hD0, 1'b1, 1'b0);
        chk("arst_first_imm", a_out_imm, 32'hFFFF_FFFC);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, $urandom, 3'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
